store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-write buffer directly downstream of the single-cycle ARM core's data-memory write port (MemWrite, DataAdr, WriteData).
- Absorbs stores in one cycle, then drains them in order to a slower data memory/peripheral bus over a valid/ready handshake.
- Asserts Stall back to the core when it cannot accept a store.
- Provides store-to-load forwarding so loads observe buffered stores before they drain.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; reset is asserted while 0.
- MemWrite  input  1  core store request this cycle.
- DataAdr  input  AW  store address.
- WriteData  input  DW  store data.
- Stall  output  1  store not accepted this cycle; core must hold the store.
- ReadAdr  input  AW  load address for forwarding lookup.
- FwdHit  output  1  a buffered entry matches ReadAdr.
- FwdData  output  DW  data of the youngest matching entry.
- MValid  output  1  head entry is presented downstream.
- MReady  input  1  downstream accepts the head entry.
- MAddr  output  AW  head address.
- MData  output  DW  head data.
- Empty  output  1  no entries held.
- Count  output  $clog2(DEPTH)+1  number of entries held.

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and counter. Pointers wrap modulo DEPTH.
- Full is defined as Count == DEPTH.
- Reset: asynchronous clear when reset == 0.
  - Pointers and Count go to 0; Empty=1, MValid=0, FwdHit=0. MAddr, MData and FwdData are 0 when their qualifier is low.
  - Entry contents are don't-care.
  - Reset mid-drain discards all entries; no MValid appears until a new store is accepted.
- Enqueue: when MemWrite && !Stall at the rising edge, write {DataAdr, WriteData} at tail, advance tail, increment Count.
  - Latency from enqueue to MValid: 1 cycle, even when the buffer was empty. There is no bypass.
- Stall = MemWrite && full. Stall is combinational and is independent of MReady.
  - A same-cycle dequeue does not free a slot for the stalled store; the store is accepted on the next cycle.
- Dequeue:
  - MValid = !Empty.
  - A transfer occurs when MValid && MReady at the rising edge; head advances and Count decrements.
  - While MValid && !MReady, MAddr and MData are held stable.
- Simultaneous enqueue and dequeue: Count is unchanged and both pointers advance.
- Forwarding (combinational):
  - Compare ReadAdr[AW-1:2] against the addresses of all valid entries, ignoring byte offset.
  - FwdHit=1 on any match; FwdData is the data of the youngest matching entry, found by priority from tail-1 toward head.
  - A store being enqueued in the same cycle is not visible to forwarding.
  - An entry being dequeued in the same cycle is still visible to forwarding.
- Counter width ensures Count never wraps; the DEPTH value is representable.

Optional Feature:
- Macro: STORE_WRITE_BUFFER_MERGE_EN.
- Defined (write coalescing):
  - If MemWrite, the buffer is non-empty, and DataAdr[AW-1:2] equals the address of the youngest entry (tail-1), WriteData overwrites that entry's data instead of allocating a new slot. Count and tail are unchanged.
  - Merge is suppressed when the youngest entry is the head and MValid is 1, so that MData stays stable.
  - Stall is 0 whenever a merge is possible, including when full.
- Undefined: every accepted store allocates an entry; the merge logic is absent.

Decomposition:
- Package store_wb_pkg holds:
  - AW_DEF and DW_DEF constants.
  - typedef wb_entry_t struct {addr, data}.
  - Function ptr_inc(ptr) for modulo-DEPTH pointer increment.
- One sub-module, wb_fifo_ctrl, owns head, tail, Count, Full and Empty.
- The top level owns entry storage, the forwarding priority search and merge logic.

Test Plan:
- Reset then idle: reset=0 for 17 ns, released → Empty=1, Count=0, MValid=0, Stall=0.
- Single store: MemWrite=1, DataAdr=100, WriteData=7, MReady=0 → next cycle MValid=1, MAddr=100, MData=7, Count=1. After 3 held cycles, assert MReady → Empty=1 one cycle later.
- Fill and stall: DEPTH=4, MReady=0, stores to 0, 4, 8, 12, 16:
  - Fifth store sees Stall=1 and Count=4.
  - MReady=1 for one cycle → that cycle Stall is still 1; the next cycle the store to 16 is accepted.
  - Drain order is 0, 4, 8, 12, 16.
- Forwarding:
  - Buffer holds (96, 5), (100, 7), (96, 9). ReadAdr=96 → FwdHit=1, FwdData=9.
  - ReadAdr=98 → FwdData=9, because the byte offset is ignored.
  - ReadAdr=104 → FwdHit=0.
- Wrap-around: 10 stores with MReady toggling every cycle → pointers wrap, output order is preserved, and Count stays consistent with the scoreboard.
- Merge (macro defined): with MReady=0, stores (96, 5) then (200, 1) then (200, 3) → Count=2, second entry data=3. Without the macro, Count=3.

Source files
------------

// File: rtl/store_wb_pkg.sv
// ============================================================================
// Module : store_wb_pkg
// Desc   : Shared constants, entry type and pointer helper for the
//          store write buffer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_wb_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   // One buffered store: full byte address plus write data
   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] data;
   } wb_entry_t;

   // Modulo-depth pointer increment; works for any depth, not only powers of 2
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo_ctrl.sv
// ============================================================================
// Module : wb_fifo_ctrl
// Desc   : Head/tail pointers and occupancy counter for the store write
//          buffer. The caller guarantees push only when not full and pop
//          only when not empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo_ctrl
   import store_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   output logic [$clog2(DEPTH)-1:0] o_head,
   output logic [$clog2(DEPTH)-1:0] o_tail,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH) + 1;

   logic [c_PW-1:0] r_head;
   logic [c_PW-1:0] r_tail;
   logic [c_CW-1:0] r_count;

   // Advance pointers on push/pop; the counter only moves when exactly one happens
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_tail <= c_PW'(ptr_inc(32'(r_tail), 32'(DEPTH)));
         end
         if (i_pop) begin
            r_head <= c_PW'(ptr_inc(32'(r_head), 32'(DEPTH)));
         end
         if (i_push && !i_pop) begin
            r_count <= r_count + c_CW'(1);
         end else if (!i_push && i_pop) begin
            r_count <= r_count - c_CW'(1);
         end
      end
   end

   assign o_head  = r_head;
   assign o_tail  = r_tail;
   assign o_count = r_count;
   assign o_full  = (r_count == c_CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/store_write_buffer.sv
// ============================================================================
// Module : store_write_buffer
// Desc   : Posted-write buffer between the core data-memory write port and a
//          slower valid/ready memory bus, with store-to-load forwarding.
// Config : STORE_WRITE_BUFFER_MERGE_EN - coalesce a store into the youngest
//          entry when the word address matches.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_buffer
   import store_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   MemWrite,
   input  logic [AW-1:0]          DataAdr,
   input  logic [DW-1:0]          WriteData,
   output logic                   Stall,
   input  logic [AW-1:0]          ReadAdr,
   output logic                   FwdHit,
   output logic [DW-1:0]          FwdData,
   output logic                   MValid,
   input  logic                   MReady,
   output logic [AW-1:0]          MAddr,
   output logic [DW-1:0]          MData,
   output logic                   Empty,
   output logic [$clog2(DEPTH):0] Count
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH) + 1;

   logic [AW-1:0]   r_addr [DEPTH];
   logic [DW-1:0]   r_data [DEPTH];

   logic [c_PW-1:0] w_head;
   logic [c_PW-1:0] w_tail;
   logic [c_PW-1:0] w_youngest;
   logic [c_CW-1:0] w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_merge;
   logic            w_hit;
   logic [DW-1:0]   w_fdata;
   logic            w_unused;

   wb_fifo_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_tail  (w_tail),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_youngest = w_tail - c_PW'(1);

`ifdef STORE_WRITE_BUFFER_MERGE_EN
   // Coalescing into the head is blocked while it is presented, so MData stays stable
   assign w_merge = MemWrite && !w_empty && (w_youngest != w_head) &&
                    (r_addr[w_youngest][AW-1:2] == DataAdr[AW-1:2]);
`else
   assign w_merge = 1'b0;
`endif

   // A dequeue in the same cycle does not free the slot for a stalled store
   assign Stall  = MemWrite && w_full && !w_merge;
   assign w_push = MemWrite && !Stall && !w_merge;
   assign w_pop  = !w_empty && MReady;

   // Entry storage: allocate at tail, or overwrite youngest data on a merge
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[w_tail] <= DataAdr;
         r_data[w_tail] <= WriteData;
      end else if (w_merge) begin
         r_data[w_youngest] <= WriteData;
      end
   end

   // Walk entries oldest to youngest so the last match seen is the youngest
   always_comb begin
      w_hit   = 1'b0;
      w_fdata = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((c_CW'(k) < w_count) &&
             (r_addr[w_head + c_PW'(k)][AW-1:2] == ReadAdr[AW-1:2])) begin
            w_hit   = 1'b1;
            w_fdata = r_data[w_head + c_PW'(k)];
         end
      end
   end

   // Byte offset of the load address plays no part in the word match
   assign w_unused = ^ReadAdr[1:0];

   assign FwdHit  = w_hit;
   assign FwdData = w_fdata;
   assign MValid  = !w_empty;
   assign MAddr   = w_empty ? '0 : r_addr[w_head];
   assign MData   = w_empty ? '0 : r_data[w_head];
   assign Empty   = w_empty;
   assign Count   = w_count;

endmodule

`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none

module tb_store_write_buffer;
   import store_wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

`ifdef STORE_WRITE_BUFFER_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          MemWrite  = 1'b0;
   logic [AW-1:0] DataAdr   = '0;
   logic [DW-1:0] WriteData = '0;
   logic          Stall;
   logic [AW-1:0] ReadAdr   = '0;
   logic          FwdHit;
   logic [DW-1:0] FwdData;
   logic          MValid;
   logic          MReady    = 1'b0;
   logic [AW-1:0] MAddr;
   logic [DW-1:0] MData;
   logic          Empty;
   logic [2:0]    Count;

   int checks = 0;
   int errors = 0;

   wb_entry_t sb[$];

   store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .Stall     (Stall),
      .ReadAdr   (ReadAdr),
      .FwdHit    (FwdHit),
      .FwdData   (FwdData),
      .MValid    (MValid),
      .MReady    (MReady),
      .MAddr     (MAddr),
      .MData     (MData),
      .Empty     (Empty),
      .Count     (Count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: compare against the queue model, then advance it with this cycle's handshakes
   always @(negedge clk) begin : mon
      int        sz;
      bit        mhit;
      logic [DW-1:0] mfd;
      bit        mmerge;
      bit        mstall;
      wb_entry_t tmp;
      if (!reset) begin
         check("rst_empty",   64'(Empty),   64'd1);
         check("rst_mvalid",  64'(MValid),  64'd0);
         check("rst_count",   64'(Count),   64'd0);
         check("rst_fwdhit",  64'(FwdHit),  64'd0);
         check("rst_fwddata", 64'(FwdData), 64'd0);
         sb.delete();
      end else begin
         sz   = sb.size();
         mhit = 1'b0;
         mfd  = '0;
         for (int i = 0; i < sz; i++) begin
            if (sb[i].addr[AW-1:2] == ReadAdr[AW-1:2]) begin
               mhit = 1'b1;
               mfd  = sb[i].data;
            end
         end
         mmerge = MERGE && MemWrite && (sz > 1) && (sb[sz-1].addr[AW-1:2] == DataAdr[AW-1:2]);
         mstall = MemWrite && (sz == DEPTH) && !mmerge;
         check("sb_stall",   64'(Stall),   64'(mstall));
         check("sb_count",   64'(Count),   64'(sz));
         check("sb_empty",   64'(Empty),   64'(sz == 0));
         check("sb_mvalid",  64'(MValid),  64'(sz != 0));
         check("sb_fwdhit",  64'(FwdHit),  64'(mhit));
         check("sb_fwddata", 64'(FwdData), 64'(mfd));
         if (sz != 0) begin
            check("sb_maddr", 64'(MAddr), 64'(sb[0].addr));
            check("sb_mdata", 64'(MData), 64'(sb[0].data));
         end else begin
            check("sb_maddr_idle", 64'(MAddr), 64'd0);
            check("sb_mdata_idle", 64'(MData), 64'd0);
         end
         if (mmerge) begin
            tmp      = sb[sz-1];
            tmp.data = WriteData;
            sb[sz-1] = tmp;
         end
         if (sz != 0 && MReady) void'(sb.pop_front());
         if (MemWrite && !mstall && !mmerge) sb.push_back('{addr: DataAdr, data: WriteData});
      end
   end

   typedef struct {
      bit            mw;
      logic [AW-1:0] adr;
      logic [DW-1:0] wd;
      bit            mr;
      logic [AW-1:0] ra;
      bit            e_stall;
      int            e_count;
      bit            chk_fwd;
      bit            e_hit;
      logic [DW-1:0] e_fd;
   } vec_t;

   function automatic vec_t v(bit mw, int unsigned adr, int unsigned wd, bit mr, int unsigned ra,
                              bit st, int cnt, bit cf, bit hit, int unsigned fd);
      vec_t r;
      r.mw = mw; r.adr = adr; r.wd = wd; r.mr = mr; r.ra = ra;
      r.e_stall = st; r.e_count = cnt; r.chk_fwd = cf; r.e_hit = hit; r.e_fd = fd;
      return r;
   endfunction

   task automatic drive(input bit mw, input logic [AW-1:0] adr, input logic [DW-1:0] wd, input bit mr);
      @(posedge clk);
      #1;
      MemWrite  = mw;
      DataAdr   = adr;
      WriteData = wd;
      MReady    = mr;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n = 0;
      do begin
         drive(1'b0, '0, '0, 1'b1);
         n++;
      end while (Count != 0 && n < 20);
      check(name, 64'(Count), 64'd0);
      drive(1'b0, '0, '0, 1'b0);
   endtask

   initial begin : watchdog
      #100000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stim
      vec_t tbl[$];
      int   acc;
      int   guard;
      bit   tog;

      // single store, held three cycles, then drained
      tbl.push_back(v(1, 100, 7, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // fill, stall, dequeue does not free the slot this cycle, drain in order
      tbl.push_back(v(1,  0, 'hA0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1,  4, 'hA1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(1,  8, 'hA2, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(v(1, 12, 'hA3, 0, 0, 0, 3, 0, 0, 0));
      tbl.push_back(v(1, 16, 'hA4, 0, 0, 1, 4, 0, 0, 0));
      tbl.push_back(v(1, 16, 'hA4, 1, 0, 1, 4, 0, 0, 0));
      tbl.push_back(v(1, 16, 'hA4, 0, 0, 0, 3, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 4, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 3, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // forwarding: same-cycle store invisible, youngest wins, byte offset ignored
      tbl.push_back(v(1,  96, 5, 0,  96, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, 100, 7, 0,  96, 0, 1, 1, 1, 5));
      tbl.push_back(v(1,  96, 9, 0,  96, 0, 2, 1, 1, 5));
      tbl.push_back(v(0,   0, 0, 0,  96, 0, 3, 1, 1, 9));
      tbl.push_back(v(0,   0, 0, 0,  98, 0, 3, 1, 1, 9));
      tbl.push_back(v(0,   0, 0, 0, 104, 0, 3, 1, 0, 0));
      tbl.push_back(v(0,   0, 0, 0, 100, 0, 3, 1, 1, 7));
      tbl.push_back(v(0,   0, 0, 1,  96, 0, 3, 1, 1, 9));
      tbl.push_back(v(0,   0, 0, 1,  96, 0, 2, 1, 1, 9));
      tbl.push_back(v(0,   0, 0, 1,  96, 0, 1, 1, 1, 9));
      tbl.push_back(v(0,   0, 0, 0,  96, 0, 0, 1, 0, 0));

      #17 reset = 1'b1;
      @(negedge clk);
      check("idle_empty",  64'(Empty),  64'd1);
      check("idle_count",  64'(Count),  64'd0);
      check("idle_mvalid", 64'(MValid), 64'd0);
      check("idle_stall",  64'(Stall),  64'd0);

      foreach (tbl[r]) begin
         @(posedge clk);
         #1;
         MemWrite  = tbl[r].mw;
         DataAdr   = tbl[r].adr;
         WriteData = tbl[r].wd;
         MReady    = tbl[r].mr;
         ReadAdr   = tbl[r].ra;
         @(negedge clk);
         check($sformatf("row%0d_stall", r), 64'(Stall), 64'(tbl[r].e_stall));
         check($sformatf("row%0d_count", r), 64'(Count), 64'(tbl[r].e_count));
         if (tbl[r].chk_fwd) begin
            check($sformatf("row%0d_fwdhit", r),  64'(FwdHit),  64'(tbl[r].e_hit));
            check($sformatf("row%0d_fwddata", r), 64'(FwdData), 64'(tbl[r].e_fd));
         end
      end
      ReadAdr = '0;

      // wrap-around with MReady toggling; stalled stores are retried
      acc   = 0;
      guard = 0;
      tog   = 1'b0;
      while (acc < 10 && guard < 60) begin
         drive(1'b1, 32'h200 + 32'(4 * acc), 32'hC0 + 32'(acc), tog);
         tog = !tog;
         if (!Stall) acc++;
         guard++;
      end
      check("wrap_accepted", 64'(acc), 64'd10);
      drain("wrap_drain");

      // coalescing: (96,5) (200,1) (200,3)
      drive(1'b1,  96, 5, 1'b0);
      drive(1'b1, 200, 1, 1'b0);
      drive(1'b1, 200, 3, 1'b0);
      drive(1'b0,   0, 0, 1'b0);
      check("merge_count", 64'(Count), MERGE ? 64'd2 : 64'd3);
      drain("merge_drain");

      // a store matching the presented head never merges
      drive(1'b1, 300, 1, 1'b0);
      drive(1'b1, 300, 2, 1'b0);
      drive(1'b0,   0, 0, 1'b0);
      check("head_nomerge_count", 64'(Count), 64'd2);
      drain("head_drain");

      // full buffer: a store matching the youngest entry is absorbed without stall
      drive(1'b1, 32'h400, 1, 1'b0);
      drive(1'b1, 32'h404, 2, 1'b0);
      drive(1'b1, 32'h408, 3, 1'b0);
      drive(1'b1, 32'h40C, 4, 1'b0);
      drive(1'b1, 32'h40C, 5, 1'b0);
      check("full_merge_stall", 64'(Stall), MERGE ? 64'd0 : 64'd1);
      drain("full_drain");

      // reset mid-drain discards entries; no MValid until a new store
      drive(1'b1, 32'h500, 1, 1'b0);
      drive(1'b1, 32'h504, 2, 1'b0);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      MReady   = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      check("midrst_mvalid", 64'(MValid), 64'd0);
      check("midrst_count",  64'(Count),  64'd0);
      #3 reset = 1'b1;
      drive(1'b0, 0, 0, 1'b1);
      drive(1'b0, 0, 0, 1'b1);
      check("postrst_mvalid", 64'(MValid), 64'd0);
      drive(1'b1, 32'h600, 6, 1'b0);
      drive(1'b0, 0, 0, 1'b0);
      check("postrst_store_mvalid", 64'(MValid), 64'd1);
      check("postrst_store_maddr",  64'(MAddr),  64'h600);
      drain("postrst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
